// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the IF stage: reset/exception PCs, fetch window, IF/ID payload.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES   = 32'h0000_2000;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        bd;
    logic        exc;
    logic [4:0]  exc_code;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP, pc: 32'h0, pc8: 32'h0, bd: 1'b0,
                                      exc: 1'b0, exc_code: 5'd0};

  // Window end is formed in 33 bits so a window touching 2^32 cannot wrap.
  function automatic logic fetch_fault(input logic [31:0] pc, input logic [31:0] base,
                                       input logic [31:0] bytes);
    logic [32:0] w_end;
    w_end = {1'b0, base} + {1'b0, bytes};
    return (pc[1:0] != 2'b00) || ({1'b0, pc} < {1'b0, base}) || ({1'b0, pc} >= w_end);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Control, instruction-memory and IF/ID bundle between the fetch unit and its neighbours.
interface fetch_unit_if;

  logic        stall;
  logic        br_take;
  logic [31:0] br_target;
  logic        id_is_jb;
  logic        exc_take;
  logic        eret_take;
  logic [31:0] epc;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_bd;
  logic        id_exc;
  logic [4:0]  id_exc_code;

  modport master (
    output stall, br_take, br_target, id_is_jb, exc_take, eret_take, epc, imem_rdata,
    input  imem_addr, pc, id_instr, id_pc, id_pc8, id_bd, id_exc, id_exc_code
  );

  modport slave (
    input  stall, br_take, br_target, id_is_jb, exc_take, eret_take, epc, imem_rdata,
    output imem_addr, pc, id_instr, id_pc, id_pc8, id_bd, id_exc, id_exc_code
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline latch: flush loads a bubble, hold keeps the current contents.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_flush,
  input  logic   i_hold,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_flush) begin
      r_q <= IF_ID_BUBBLE;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register with redirect/exception priority mux, fetch-fault detection, IF/ID latch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] ResetPc   = RESET_PC,
  parameter logic [31:0] ExcVector = EXC_VECTOR,
  parameter logic [31:0] ImBase    = IM_BASE,
  parameter logic [31:0] ImBytes   = IM_BYTES
) (
  input logic          i_clk,
  input logic          i_reset,
  fetch_unit_if.slave  bus
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_d;
  logic [31:0] w_pc_plus4;
  logic        w_fault;
  logic        w_flush;
  if_id_t      w_if_d;
  if_id_t      w_if_q;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_fault    = fetch_fault(r_pc, ImBase, ImBytes);
  assign w_flush    = bus.exc_take || bus.eret_take;

  // A stalled ID stage has not resolved its branch yet, so stall outranks br_take.
  always_comb begin
    w_pc_d = w_pc_plus4;
    if (bus.exc_take) begin
      w_pc_d = ExcVector;
    end else if (bus.eret_take) begin
      w_pc_d = bus.epc;
    end else if (bus.stall) begin
      w_pc_d = r_pc;
    end else if (bus.br_take) begin
      w_pc_d = bus.br_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pc <= ResetPc;
    end else begin
      r_pc <= w_pc_d;
    end
  end

  always_comb begin
    w_if_d          = IF_ID_BUBBLE;
    w_if_d.instr    = w_fault ? NOP : bus.imem_rdata;
    w_if_d.pc       = r_pc;
    w_if_d.pc8      = r_pc + 32'd8;
    w_if_d.bd       = bus.id_is_jb;
    w_if_d.exc      = w_fault;
    w_if_d.exc_code = w_fault ? EXC_ADEL : 5'd0;
  end

  fetch_unit_if_id_reg u_if_id (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (w_flush),
    .i_hold  (bus.stall),
    .i_d     (w_if_d),
    .o_q     (w_if_q)
  );

  assign bus.imem_addr   = r_pc[12:2];
  assign bus.pc          = r_pc;
  assign bus.id_instr    = w_if_q.instr;
  assign bus.id_pc       = w_if_q.pc;
  assign bus.id_pc8      = w_if_q.pc8;
  assign bus.id_bd       = w_if_q.bd;
  assign bus.id_exc      = w_if_q.exc;
  assign bus.id_exc_code = w_if_q.exc_code;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; driver queues expected post-edge state, monitor checks it.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] id_pc;
    logic [31:0] pc8;
    logic        bd;
    logic        exc;
    logic [4:0]  code;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t q_exp[$];

  fetch_unit_if bus ();

  fetch_unit dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: each word tags its own word address.
  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return 32'h8C00_0000 | {21'd0, a};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  function automatic exp_t e_bub(input logic [31:0] pc);
    exp_t e;
    e = '{pc: pc, instr: 32'h0, id_pc: 32'h0, pc8: 32'h0, bd: 1'b0, exc: 1'b0, code: 5'd0};
    return e;
  endfunction

  function automatic exp_t e_ok(input logic [31:0] pc, input logic [31:0] idpc,
                                input logic [31:0] pc8, input logic bd);
    exp_t e;
    logic [31:0] t;
    t = idpc;
    e = '{pc: pc, instr: mem_word(t[12:2]), id_pc: idpc, pc8: pc8, bd: bd, exc: 1'b0,
          code: 5'd0};
    return e;
  endfunction

  function automatic exp_t e_flt(input logic [31:0] pc, input logic [31:0] idpc,
                                 input logic [31:0] pc8, input logic bd);
    exp_t e;
    e = '{pc: pc, instr: 32'h0, id_pc: idpc, pc8: pc8, bd: bd, exc: 1'b1, code: 5'd4};
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic st, input logic br, input logic [31:0] tgt,
                     input logic jb, input logic ex, input logic er, input logic [31:0] ep,
                     input exp_t e);
    reset         = rst;
    bus.stall     = st;
    bus.br_take   = br;
    bus.br_target = tgt;
    bus.id_is_jb  = jb;
    bus.exc_take  = ex;
    bus.eret_take = er;
    bus.epc       = ep;
    @(posedge clk);
    q_exp.push_back(e);
    #1;
  endtask

  task automatic idle(input exp_t e);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        p = e.pc;
        chk("pc", bus.pc, e.pc);
        chk("imem_addr", {21'd0, bus.imem_addr}, {21'd0, p[12:2]});
        chk("id_instr", bus.id_instr, e.instr);
        chk("id_pc", bus.id_pc, e.id_pc);
        chk("id_pc8", bus.id_pc8, e.pc8);
        chk("id_bd", {31'd0, bus.id_bd}, {31'd0, e.bd});
        chk("id_exc", {31'd0, bus.id_exc}, {31'd0, e.exc});
        chk("id_exc_code", {27'd0, bus.id_exc_code}, {27'd0, e.code});
      end
    end
  end

  initial begin : driver
    int guard;
    n_tests = 0;
    n_fail  = 0;
    // Reset for two cycles, then sequential fetch.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e_bub(32'h3000));
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e_bub(32'h3000));
    idle(e_ok(32'h3004, 32'h3000, 32'h3008, 1'b0));
    idle(e_ok(32'h3008, 32'h3004, 32'h300C, 1'b0));
    // Taken branch at 0x3008: delay slot latched with bd.
    cyc(1'b1, 1'b0, 1'b1, 32'h3100, 1'b1, 1'b0, 1'b0, 32'h0,
        e_ok(32'h3100, 32'h3008, 32'h3010, 1'b1));
    idle(e_ok(32'h3104, 32'h3100, 32'h3108, 1'b0));
    // Branch while stalled: target ignored, everything frozen.
    cyc(1'b1, 1'b1, 1'b1, 32'h3200, 1'b1, 1'b0, 1'b0, 32'h0,
        e_ok(32'h3104, 32'h3100, 32'h3108, 1'b0));
    idle(e_ok(32'h3108, 32'h3104, 32'h310C, 1'b0));
    // Redirect to 0x3010, then three stall cycles.
    cyc(1'b1, 1'b0, 1'b1, 32'h3010, 1'b0, 1'b0, 1'b0, 32'h0,
        e_ok(32'h3010, 32'h3108, 32'h3110, 1'b0));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
          e_ok(32'h3010, 32'h3108, 32'h3110, 1'b0));
    end
    idle(e_ok(32'h3014, 32'h3010, 32'h3018, 1'b0));
    // Exception beats a same-cycle branch.
    cyc(1'b1, 1'b0, 1'b1, 32'h3300, 1'b1, 1'b1, 1'b0, 32'h0, e_bub(32'h4180));
    idle(e_ok(32'h4184, 32'h4180, 32'h4188, 1'b0));
    // Eret return.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3020, e_bub(32'h3020));
    idle(e_ok(32'h3024, 32'h3020, 32'h3028, 1'b0));
    idle(e_ok(32'h3028, 32'h3024, 32'h302C, 1'b0));
    // Misaligned target.
    cyc(1'b1, 1'b0, 1'b1, 32'h3002, 1'b1, 1'b0, 1'b0, 32'h0,
        e_ok(32'h3002, 32'h3028, 32'h3030, 1'b1));
    cyc(1'b1, 1'b0, 1'b1, 32'h5000, 1'b0, 1'b0, 1'b0, 32'h0,
        e_flt(32'h5000, 32'h3002, 32'h300A, 1'b0));
    // Window end and last legal word.
    cyc(1'b1, 1'b0, 1'b1, 32'h4FFC, 1'b0, 1'b0, 1'b0, 32'h0,
        e_flt(32'h4FFC, 32'h5000, 32'h5008, 1'b0));
    cyc(1'b1, 1'b0, 1'b1, 32'h2FFC, 1'b0, 1'b0, 1'b0, 32'h0,
        e_ok(32'h2FFC, 32'h4FFC, 32'h5004, 1'b0));
    // Below base, then 32-bit wrap of pc and link value.
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0,
        e_flt(32'hFFFF_FFFC, 32'h2FFC, 32'h3004, 1'b0));
    idle(e_flt(32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0004, 1'b0));
    idle(e_flt(32'h0000_0004, 32'h0000_0000, 32'h0000_0008, 1'b0));
    // Reset wins over stall, branch and exception.
    cyc(1'b0, 1'b1, 1'b1, 32'h3100, 1'b1, 1'b1, 1'b0, 32'h0, e_bub(32'h3000));
    idle(e_ok(32'h3004, 32'h3000, 32'h3008, 1'b0));
    idle(e_ok(32'h3008, 32'h3004, 32'h300C, 1'b0));

    guard = 0;
    while (q_exp.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #2;
    if (q_exp.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
